// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory responder.
package dmem_pkg;

    // Access type codes: bits [1:0] give the size, bit 2 selects zero extension.
    localparam logic [2:0] MtWord  = 3'b000;
    localparam logic [2:0] MtHalf  = 3'b001;
    localparam logic [2:0] MtByte  = 3'b010;
    localparam logic [2:0] MtHalfU = 3'b101;
    localparam logic [2:0] MtByteU = 3'b110;

    typedef enum logic [1:0] {
        SzWord = 2'b00,
        SzHalf = 2'b01,
        SzByte = 2'b10
    } mem_size_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    // Undefined size codes fall back to a word access.
    function automatic mem_size_e mem_size(input logic [2:0] mem_type);
        case (mem_type[1:0])
            2'b01:   return SzHalf;
            2'b10:   return SzByte;
            default: return SzWord;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] mem_type);
        return mem_type[2];
    endfunction

    function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] addr_lo);
        case (sz)
            SzHalf:  return addr_lo[0];
            SzByte:  return 1'b0;
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Lane steering: load extraction/extension and store byte-enable generation.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_type,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic [31:0] wword,
    output logic [3:0]  byte_en,
    output logic        misaligned
);

    mem_size_e   sz;
    logic [31:0] shifted;

    // Select the addressed lane, extend it, and replicate store data across lanes.
    always_comb begin
        sz         = mem_size(mem_type);
        misaligned = is_misaligned(sz, addr_lo);
        shifted    = rword >> {addr_lo, 3'b000};
        rdata_ext  = shifted;
        wword      = wdata;
        byte_en    = 4'b1111;
        case (sz)
            SzHalf: begin
                rdata_ext = is_unsigned(mem_type) ? {16'h0000, shifted[15:0]}
                                                  : {{16{shifted[15]}}, shifted[15:0]};
                wword     = {2{wdata[15:0]}};
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SzByte: begin
                rdata_ext = is_unsigned(mem_type) ? {24'h000000, shifted[7:0]}
                                                  : {{24{shifted[7]}}, shifted[7:0]};
                wword     = {4{wdata[7:0]}};
                byte_en   = 4'b0001 << addr_lo;
            end
            default: ;
        endcase
        // A misaligned store must leave the array untouched.
        if (misaligned) begin
            byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with a fixed per-access stall and lane steering.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        EX_mem_rvalid,
    input  logic        EX_mem_wvalid,
    input  logic [31:0] EX_mem_addr,
    input  logic [2:0]  EX_mem_type,
    input  logic [31:0] EX_mem_wdata,
    output logic        MEM_mem_rready,
    output logic        MEM_mem_wready,
    output logic [31:0] MEM_mem_rdata,
    output logic        MEM_mem_ale
);

    localparam int unsigned Words = 1 << ADDR_W;

    logic [31:0] mem [Words];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ale_q, ale_d;
    // Result captured at acceptance, released when the stall ends.
    logic [31:0] pend_rdata_q, pend_rdata_d;
    logic        pend_load_q, pend_load_d;
    logic        pend_ale_q, pend_ale_d;

    logic [ADDR_W-1:0] widx;
    logic [31:0]       rword;
    logic [31:0]       rdata_ext;
    logic [31:0]       wword;
    logic [3:0]        byte_en;
    logic              misaligned;
    logic              accept;
    logic              is_store;
    logic              is_load;
    logic              unused_addr;

    // Upper address bits alias onto the array.
    assign widx        = EX_mem_addr[ADDR_W+1:2];
    assign unused_addr = ^EX_mem_addr[31:ADDR_W+2];
    assign rword       = mem[widx];

    assign accept   = !rstn && (state_q == StIdle) && (EX_mem_rvalid || EX_mem_wvalid);
    assign is_store = EX_mem_wvalid;
    assign is_load  = EX_mem_rvalid && !EX_mem_wvalid;

    dmem_lane u_lane (
        .addr_lo    (EX_mem_addr[1:0]),
        .mem_type   (EX_mem_type),
        .rword      (rword),
        .wdata      (EX_mem_wdata),
        .rdata_ext  (rdata_ext),
        .wword      (wword),
        .byte_en    (byte_en),
        .misaligned (misaligned)
    );

    // Commit stores at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && is_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[widx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    // Next-state: accept in idle, count down the stall, publish the result on completion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        ale_d        = 1'b0;
        pend_rdata_d = pend_rdata_q;
        pend_load_d  = pend_load_q;
        pend_ale_d   = pend_ale_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        if (is_load && !misaligned) begin
                            rdata_d = rdata_ext;
                        end
                        ale_d = misaligned;
                    end else begin
                        state_d      = StBusy;
                        cnt_d        = 4'(WAIT);
                        pend_rdata_d = rdata_ext;
                        pend_load_d  = is_load && !misaligned;
                        pend_ale_d   = misaligned;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    if (pend_load_q) begin
                        rdata_d = pend_rdata_q;
                    end
                    ale_d = pend_ale_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            rdata_q      <= 32'd0;
            ale_q        <= 1'b0;
            pend_rdata_q <= 32'd0;
            pend_load_q  <= 1'b0;
            pend_ale_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            ale_q        <= ale_d;
            pend_rdata_q <= pend_rdata_d;
            pend_load_q  <= pend_load_d;
            pend_ale_q   <= pend_ale_d;
        end
    end

    assign MEM_mem_rready = (state_q == StIdle);
    assign MEM_mem_wready = (state_q == StIdle);
    assign MEM_mem_rdata  = rdata_q;
    assign MEM_mem_ale    = ale_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: three responders (WAIT 0, 2, 4) checked against a byte-level memory model.
module tb_dmem_responder;

    localparam int N = 3;

    logic        clk;
    logic        rstn   [N];
    logic        rvalid [N];
    logic        wvalid [N];
    logic [31:0] addr   [N];
    logic [2:0]  typ    [N];
    logic [31:0] wdata  [N];
    logic        rready [N];
    logic        wready [N];
    logic [31:0] rdata  [N];
    logic        ale    [N];

    logic [7:0]  mm        [N][4096];
    logic [31:0] exp_rdata [N];
    logic [2:0]  type_tab  [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
    int          checks;
    int          errors;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W (10),
            .WAIT   (2 * g)
        ) u_dut (
            .clk            (clk),
            .rstn           (rstn[g]),
            .EX_mem_rvalid  (rvalid[g]),
            .EX_mem_wvalid  (wvalid[g]),
            .EX_mem_addr    (addr[g]),
            .EX_mem_type    (typ[g]),
            .EX_mem_wdata   (wdata[g]),
            .MEM_mem_rready (rready[g]),
            .MEM_mem_wready (wready[g]),
            .MEM_mem_rdata  (rdata[g]),
            .MEM_mem_ale    (ale[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] t);
        case (t[1:0])
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                               input logic [2:0] t);
        int          b;
        int          nb;
        logic [31:0] v;
        b  = int'(a[11:0]);
        nb = size_bytes(t);
        v  = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mm[d][b+i]) << (8 * i));
        if (!t[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the completion cycle
    // with the request still driven, so the caller either chains or goes idle.
    task automatic access(input int d, input bit ld, input bit st, input logic [31:0] a,
                          input logic [2:0] t, input logic [31:0] wd, input string tag);
        int          nb;
        bit          mis;
        logic [31:0] prev;
        nb   = size_bytes(t);
        mis  = (int'(a[11:0]) % nb) != 0;
        prev = exp_rdata[d];
        check({tag, " rready_pre"}, 32'(rready[d]), 32'd1);
        rvalid[d] = ld;
        wvalid[d] = st;
        addr[d]   = a;
        typ[d]    = t;
        wdata[d]  = wd;
        if (st) begin
            if (!mis) for (int i = 0; i < nb; i++) mm[d][int'(a[11:0]) + i] = wd[8*i +: 8];
        end else if (ld && !mis) begin
            exp_rdata[d] = model_load(d, a, t);
        end
        for (int k = 0; k < 2 * d; k++) begin
            @(negedge clk);
            check({tag, " rready_busy"}, 32'(rready[d]), 32'd0);
            check({tag, " wready_busy"}, 32'(wready[d]), 32'd0);
            check({tag, " ale_busy"}, 32'(ale[d]), 32'd0);
            check({tag, " rdata_busy"}, rdata[d], prev);
        end
        @(negedge clk);
        check({tag, " rready_done"}, 32'(rready[d]), 32'd1);
        check({tag, " wready_done"}, 32'(wready[d]), 32'd1);
        check({tag, " rdata_done"}, rdata[d], exp_rdata[d]);
        check({tag, " ale_done"}, 32'(ale[d]), 32'(mis));
    endtask

    task automatic idle(input int d);
        rvalid[d] = 1'b0;
        wvalid[d] = 1'b0;
        @(negedge clk);
        check("idle ale", 32'(ale[d]), 32'd0);
        check("idle rready", 32'(rready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        int          op;
        checks = 0;
        errors = 0;
        for (int d = 0; d < N; d++) begin
            rstn[d]      = 1'b1;
            rvalid[d]    = 1'b0;
            wvalid[d]    = 1'b0;
            addr[d]      = 32'd0;
            typ[d]       = 3'd0;
            wdata[d]     = 32'd0;
            exp_rdata[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < N; d++) rstn[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("reset rready", 32'(rready[d]), 32'd1);
            check("reset wready", 32'(wready[d]), 32'd1);
            check("reset rdata", rdata[d], 32'd0);
            check("reset ale", 32'(ale[d]), 32'd0);
        end

        // Give every word of the test window a known value.
        for (int d = 0; d < N; d++) begin
            for (int w = 0; w < 16; w++) access(d, 1'b0, 1'b1, 32'(4 * w), 3'b000, $urandom, "preload");
            idle(d);
        end

        // Zero-wait store then back-to-back load of the same word.
        access(0, 1'b0, 1'b1, 32'h10, 3'b000, 32'hDEADBEEF, "w0_st");
        access(0, 1'b1, 1'b0, 32'h10, 3'b000, 32'h0, "w0_ld");
        check("w0 const", rdata[0], 32'hDEADBEEF);
        idle(0);

        // Signed and unsigned byte loads.
        access(1, 1'b0, 1'b1, 32'h13, 3'b010, 32'h80, "b_st");
        access(1, 1'b1, 1'b0, 32'h13, 3'b010, 32'h0, "b_lds");
        check("b signed const", rdata[1], 32'hFFFFFF80);
        access(1, 1'b1, 1'b0, 32'h13, 3'b110, 32'h0, "b_ldu");
        check("b unsigned const", rdata[1], 32'h00000080);

        // Half store into the upper lane of a word.
        access(1, 1'b0, 1'b1, 32'h20, 3'b000, 32'hAAAAAAAA, "h_stw");
        access(1, 1'b0, 1'b1, 32'h22, 3'b001, 32'h1234, "h_sth");
        access(1, 1'b1, 1'b0, 32'h20, 3'b000, 32'h0, "h_ldw");
        check("h merge const", rdata[1], 32'h1234AAAA);

        // Misaligned load and store.
        access(1, 1'b1, 1'b0, 32'h21, 3'b000, 32'h0, "mis_ld");
        check("mis_ld rdata kept", rdata[1], 32'h1234AAAA);
        idle(1);
        access(1, 1'b0, 1'b1, 32'h23, 3'b001, 32'hBEEF, "mis_st");
        access(1, 1'b1, 1'b0, 32'h20, 3'b000, 32'h0, "mis_chk");
        check("mis_st mem kept", rdata[1], 32'h1234AAAA);

        // Both valids: store wins, load ignored, request taken once.
        access(1, 1'b1, 1'b1, 32'h30, 3'b000, 32'h55, "both");
        check("both rdata kept", rdata[1], 32'h1234AAAA);
        idle(1);
        access(1, 1'b1, 1'b0, 32'hFFFFF030, 3'b000, 32'h0, "alias_hi");
        check("alias const", rdata[1], 32'h00000055);
        access(1, 1'b1, 1'b0, 32'h00001030, 3'b000, 32'h0, "alias_b12");
        idle(1);

        // Randomised traffic inside the window with aliased upper bits.
        for (int d = 0; d < N; d++) begin
            for (int it = 0; it < 40; it++) begin
                op = $urandom_range(0, 2);
                a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
                t  = type_tab[$urandom_range(0, 4)];
                access(d, op != 1, op != 0, a, t, $urandom, "rand");
                if ($urandom_range(0, 1) == 1) idle(d);
            end
            idle(d);
        end

        // Reset during the second stall cycle of a store.
        access(2, 1'b0, 1'b1, 32'h4, 3'b000, 32'hCAFEF00D, "rst_pre_st");
        access(2, 1'b1, 1'b0, 32'h4, 3'b000, 32'h0, "rst_pre_ld");
        check("rst_pre const", rdata[2], 32'hCAFEF00D);
        rvalid[2] = 1'b0;
        wvalid[2] = 1'b1;
        addr[2]   = 32'h8;
        typ[2]    = 3'b000;
        wdata[2]  = 32'h12345678;
        for (int i = 0; i < 4; i++) mm[2][8 + i] = wdata[2][8*i +: 8];
        @(negedge clk);
        check("rst stall1", 32'(rready[2]), 32'd0);
        @(negedge clk);
        check("rst stall2", 32'(rready[2]), 32'd0);
        rstn[2]   = 1'b1;
        wvalid[2] = 1'b0;
        @(negedge clk);
        check("rst rready", 32'(rready[2]), 32'd1);
        check("rst wready", 32'(wready[2]), 32'd1);
        check("rst rdata", rdata[2], 32'd0);
        check("rst ale", 32'(ale[2]), 32'd0);
        rstn[2]      = 1'b0;
        exp_rdata[2] = 32'd0;
        @(negedge clk);
        access(2, 1'b1, 1'b0, 32'h8, 3'b000, 32'h0, "rst_post_ld");
        check("rst store kept", rdata[2], 32'h12345678);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
